// File: rtl/sync_ram_fifo_pkg.sv
// Shared helpers for the sync_ram_fifo block: parameter legality checks
// evaluated at elaboration time.
package sync_ram_fifo_pkg;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // True when a threshold level lies in 0..depth inclusive.
  function automatic bit lvl_in_range(input int lvl, input int depth);
    return (lvl >= 0) && (lvl <= depth);
  endfunction

endpackage : sync_ram_fifo_pkg

// File: rtl/sync_ram_fifo_ram.sv
// DW x DEPTH storage for sync_ram_fifo: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_ram
  import sync_ram_fifo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Store write data on the clock edge when the write is enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_ram

// File: rtl/sync_ram_fifo.sv
// Single-clock FIFO: pointer management, occupancy count, status flags,
// overflow/underflow pulses and a registered or first-word-fall-through
// read port around the fifo_ram storage array.
module sync_ram_fifo
  import sync_ram_fifo_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEPTH      = 32,
  parameter int REG        = 1,
  parameter int AFULL_LVL  = DEPTH - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_din,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_dout,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!is_pow2(DEPTH) || (DEPTH < 4)) begin : g_bad_depth
    $error("sync_ram_fifo: DEPTH must be a power of two and at least 4");
  end
  if (!lvl_in_range(AFULL_LVL, DEPTH)) begin : g_bad_afull
    $error("sync_ram_fifo: AFULL_LVL must lie in 0..DEPTH");
  end
  if (!lvl_in_range(AEMPTY_LVL, DEPTH)) begin : g_bad_aempty
    $error("sync_ram_fifo: AEMPTY_LVL must lie in 0..DEPTH");
  end

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_accept;
  logic          rd_accept;
  logic [DW-1:0] ram_rdata;

  // Flags come straight from the count register, so they lag operations
  // by one cycle and acceptance always uses the registered view.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == {CW{1'b0}});
  assign almost_full  = (count_q >= CW'(AFULL_LVL));
  assign almost_empty = (count_q <= CW'(AEMPTY_LVL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Acceptance, pointer/count next state and error pulse requests.
  always_comb begin
    wr_accept = wr_en && !full;
    rd_accept = rd_en && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A rejected request is flagged even if the other side was accepted.
    ovf_d = wr_en && full;
    unf_d = rd_en && empty;
  end

  // Pointer, occupancy and error-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {CW{1'b0}};
      rd_ptr_q <= {CW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_din),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  if (REG != 0) begin : g_reg_out
    logic [DW-1:0] rdout_q, rdout_d;
    logic          rvalid_q, rvalid_d;

    // Capture the head entry on an accepted read; hold it otherwise.
    always_comb begin
      rvalid_d = rd_accept;
      if (rd_accept) begin
        rdout_d = ram_rdata;
      end else begin
        rdout_d = rdout_q;
      end
    end

    // Output data register and its one-cycle valid strobe.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rdout_q  <= {DW{1'b0}};
        rvalid_q <= 1'b0;
      end else begin
        rdout_q  <= rdout_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rd_dout  = rdout_q;
    assign rd_valid = rvalid_q;
  end else begin : g_fwft_out
    // Head entry is presented directly; valid whenever something is stored.
    assign rd_dout  = ram_rdata;
    assign rd_valid = !empty;
  end

endmodule : sync_ram_fifo

// File: tb/tb_sync_ram_fifo.sv
// Self-checking bench for sync_ram_fifo: a registered-read instance and a
// FWFT instance share stimulus and are both compared against a queue model.
module tb_sync_ram_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_din = 8'h00;

  logic [7:0] rd_dout, f_dout;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [3:0] count, f_count;

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit [7:0] q[$];
  bit [7:0] exp_dout;
  bit       exp_valid, exp_ovf, exp_unf;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         cnt;
    logic       full;
    logic       afull;
    logic       ovf;
    logic       unf;
    logic       valid;
    logic [7:0] dout;
  } vec_t;
  vec_t vecs[$];

  sync_ram_fifo #(.DW(8), .DEPTH(8), .REG(1), .AFULL_LVL(6), .AEMPTY_LVL(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_din(wr_din), .rd_en(rd_en),
    .rd_dout(rd_dout), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_ram_fifo #(.DW(8), .DEPTH(8), .REG(0), .AFULL_LVL(6), .AEMPTY_LVL(2)) dut_fwft (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_din(wr_din), .rd_en(rd_en),
    .rd_dout(f_dout), .rd_valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d, input int cnt,
                              input logic fl, input logic af, input logic ov, input logic un,
                              input logic va, input logic [7:0] dout);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.full = fl; v.afull = af;
    v.ovf = ov; v.unf = un; v.valid = va; v.dout = dout;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_dout = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  // Compare both instances against the model's current state.
  task automatic check_model();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 8));
    chk("almost_full", 32'(almost_full), 32'(n >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    chk("rd_dout", 32'(rd_dout), 32'(exp_dout));
    chk("fwft_count", 32'(f_count), 32'(n));
    chk("fwft_valid", 32'(f_valid), 32'(n != 0));
    chk("fwft_ovf", 32'(f_ovf), 32'(exp_ovf));
    chk("fwft_unf", 32'(f_unf), 32'(exp_unf));
    if (n != 0) begin
      chk("fwft_dout", 32'(f_dout), 32'(q[0]));
    end
  endtask

  // One clock: drive at the falling edge, update the model for the rising
  // edge, then compare at the next falling edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    bit wacc, racc;
    wr_en = w; rd_en = r; wr_din = d;
    wacc = w && (q.size() < 8);
    racc = r && (q.size() > 0);
    exp_ovf = w && (q.size() == 8);
    exp_unf = r && (q.size() == 0);
    exp_valid = racc;
    @(posedge clk);
    if (racc) exp_dout = q.pop_front();
    if (wacc) q.push_back(d);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    // Reset held across clock edges with a write request active.
    reset = 1'b1; wr_en = 1'b1; wr_din = 8'hEE;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_model();
    reset = 1'b0; wr_en = 1'b0;

    // Directed table: fill, overflow, full-boundary simultaneous ops, drain,
    // underflow, empty-boundary simultaneous ops.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1'b1, 1'b0, 8'(8'h10 + k - 1), k, k == 8, k >= 6, 1'b0, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'hAA, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b1, 8'hBB, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10));
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 7 - k, 1'b0, (7 - k) >= 6, 1'b0, 1'b0, 1'b1, 8'(8'h10 + k)));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h17));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h17));
    vecs.push_back(mk(1'b1, 1'b1, 8'h77, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h17));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77));

    foreach (vecs[i]) begin
      cycle(vecs[i].w, vecs[i].r, vecs[i].d);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
      chk($sformatf("tbl%0d_aempty", i), 32'(almost_empty), 32'(vecs[i].cnt <= 2));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(vecs[i].full));
      chk($sformatf("tbl%0d_afull", i), 32'(almost_full), 32'(vecs[i].afull));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("tbl%0d_unf", i), 32'(underflow), 32'(vecs[i].unf));
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(vecs[i].valid));
      chk($sformatf("tbl%0d_dout", i), 32'(rd_dout), 32'(vecs[i].dout));
    end

    // Steady streaming at occupancy 3 across several pointer wraps.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 8'(8'hC0 + k));
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b1, 8'(8'h40 + k));
      chk("stream_count", 32'(count), 32'd3);
    end

    // Randomized traffic: write-heavy, read-heavy, then balanced.
    for (int k = 0; k < 600; k++) begin
      int wp;
      wp = (k < 200) ? 80 : ((k < 400) ? 25 : 50);
      cycle(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < (100 - wp)),
            8'($urandom_range(0, 255)));
    end

    // Asynchronous reset between edges kills an in-flight rd_valid.
    cycle(1'b1, 1'b0, 8'h33);
    cycle(1'b0, 1'b1, 8'h00);
    chk("pre_reset_valid", 32'(rd_valid), 32'd1);
    wr_en = 1'b1; rd_en = 1'b0; wr_din = 8'h99;
    #1 reset = 1'b1;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_aempty", 32'(almost_empty), 32'd1);
    chk("async_full", 32'(full), 32'd0);
    chk("async_valid", 32'(rd_valid), 32'd0);
    chk("async_dout", 32'(rd_dout), 32'd0);
    chk("async_fwft_valid", 32'(f_valid), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_model();
    reset = 1'b0; wr_en = 1'b0;

    // FWFT: written word appears without a read; popping empties it.
    cycle(1'b1, 1'b0, 8'h5A);
    chk("fwft_first_valid", 32'(f_valid), 32'd1);
    chk("fwft_first_dout", 32'(f_dout), 32'h5A);
    cycle(1'b0, 1'b1, 8'h00);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);
    chk("fwft_pop_valid", 32'(f_valid), 32'd0);
    chk("reg_pop_dout", 32'(rd_dout), 32'h5A);

    wr_en = 1'b0; rd_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_sync_ram_fifo
